multicycle_control: RTL and testbench

//  Main control FSM of the multicycle MIPS core. It sits directly downstream of the fetch

---
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences datapath enables
// and mux selects, applies the memory ready handshake, flags illegal opcodes
// and counts retired instructions.
module multicycle_control #(
  parameter int unsigned OPW  = 6,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  Opcode,
  input  logic [5:0]      Funct,
  input  logic            Zero,
  input  logic            mem_ready,
  output logic            IorD,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            PCEn,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic            illegal_op,
  output logic [CNTW-1:0] retired,
  output logic [3:0]      state
);

  localparam int unsigned SW_ = 4;

  localparam logic [SW_-1:0] S_FETCH  = 4'd0;
  localparam logic [SW_-1:0] S_DECODE = 4'd1;
  localparam logic [SW_-1:0] S_MEMADR = 4'd2;
  localparam logic [SW_-1:0] S_MEMRD  = 4'd3;
  localparam logic [SW_-1:0] S_MEMWB  = 4'd4;
  localparam logic [SW_-1:0] S_MEMWR  = 4'd5;
  localparam logic [SW_-1:0] S_EXEC   = 4'd6;
  localparam logic [SW_-1:0] S_ALUWB  = 4'd7;
  localparam logic [SW_-1:0] S_BRANCH = 4'd8;
  localparam logic [SW_-1:0] S_ADDIEX = 4'd9;
  localparam logic [SW_-1:0] S_ADDIWB = 4'd10;
  localparam logic [SW_-1:0] S_JUMP   = 4'd11;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  logic [SW_-1:0]  state_q, state_d;
  logic [CNTW-1:0] retired_q;
  logic            is_lw_q;
  logic            retire_c;

  // Funct is decoded by the ALU control, not here
  logic unused_funct;
  assign unused_funct = ^Funct;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Remember LW vs SW at dispatch so later opcode changes cannot steer MEMADR
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      is_lw_q <= 1'b0;
    else if (state_q == S_DECODE) is_lw_q <= (Opcode == OP_LW);
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired_q <= '0;
    else if (retire_c) retired_q <= retired_q + CNTW'(1);
  end

  // Next-state logic and terminal-cycle detection
  always_comb begin
    state_d  = S_FETCH;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  retire_c = 1'b1;
      S_MEMWR: begin
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
        retire_c = mem_ready;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  retire_c = 1'b1;
      S_BRANCH: retire_c = 1'b1;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: retire_c = 1'b1;
      S_JUMP:   retire_c = 1'b1;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode, wait-state strobes qualified by mem_ready, all zero in reset
  always_comb begin
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (Opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
            default:                                        illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD:  IorD = 1'b1;
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSrc       = 2'b01;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end
        default: ;
      endcase
    end
    PCEn = PCWrite | (PCWriteCond & Zero);
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, hand-built
// corner sequences and randomized instruction streams against an
// instruction-level reference model.
module tb_multicycle_control;

  localparam int unsigned OPW  = 6;
  localparam int unsigned CNTW = 4;
  localparam int unsigned CMOD = 16;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef struct packed {
    logic       IorD, IRWrite, PCWrite, PCWriteCond, PCEn, MemWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic [5:0] op;
    logic       z;
    bit         ret_inc;
  } cyc_t;

  typedef struct {
    logic       mr;
    logic [5:0] op;
    logic       z;
    logic [3:0] exp_st;
    logic       exp_pcen, exp_rw, exp_ill;
    logic [3:0] exp_ret;
  } vec_t;

  logic clk, rst, Zero, mem_ready;
  logic [OPW-1:0] Opcode;
  logic [5:0] Funct;
  logic IorD, IRWrite, PCWrite, PCWriteCond, PCEn, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic illegal_op;
  logic [CNTW-1:0] retired;
  logic [3:0] state;

  ctrl_t act_c;
  assign act_c = {IorD, IRWrite, PCWrite, PCWriteCond, PCEn, MemWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op};

  multicycle_control #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .retired(retired), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests, n_fail;
  int   exp_ret;
  cyc_t q[$];
  vec_t vecs[21];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {RT, LW, SW, BEQ, ADDI, JMP};
  endfunction

  // Expected control word for a given control step, from the state table
  function automatic ctrl_t model_ctrl(input logic [3:0] st, input logic mr,
                                       input logic z, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCWrite = mr; end
      4'd1:  begin c.ALUSrcB = 2'b11; c.illegal_op = !is_legal(op); end
      4'd2:  begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      4'd3:  c.IorD = 1'b1;
      4'd4:  begin c.MemtoReg = 1'b1; c.RegWrite = 1'b1; end
      4'd5:  begin c.IorD = 1'b1; c.MemWrite = mr; end
      4'd6:  begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b10; end
      4'd7:  begin c.RegDst = 1'b1; c.RegWrite = 1'b1; end
      4'd8:  begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b01; c.PCWriteCond = 1'b1; c.PCSrc = 2'b01; end
      4'd9:  begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      4'd10: c.RegWrite = 1'b1;
      4'd11: begin c.PCWrite = 1'b1; c.PCSrc = 2'b10; end
      default: ;
    endcase
    c.PCEn = c.PCWrite | (c.PCWriteCond & z);
    return c;
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  // Expand one instruction into its expected per-cycle steps
  task automatic push_instr(input logic [5:0] op, input int fwait, input int mwait, input logic z);
    for (int i = 0; i < fwait; i++) q.push_back('{4'd0, 1'b0, junk(), z, 1'b0});
    q.push_back('{4'd0, 1'b1, junk(), z, 1'b0});
    q.push_back('{4'd1, 1'($urandom), op, z, 1'b0});
    case (op)
      RT:   begin q.push_back('{4'd6, 1'($urandom), junk(), z, 1'b0});
                  q.push_back('{4'd7, 1'($urandom), junk(), z, 1'b1}); end
      LW:   begin q.push_back('{4'd2, 1'($urandom), junk(), z, 1'b0});
                  for (int i = 0; i < mwait; i++) q.push_back('{4'd3, 1'b0, junk(), z, 1'b0});
                  q.push_back('{4'd3, 1'b1, junk(), z, 1'b0});
                  q.push_back('{4'd4, 1'($urandom), junk(), z, 1'b1}); end
      SW:   begin q.push_back('{4'd2, 1'($urandom), junk(), z, 1'b0});
                  for (int i = 0; i < mwait; i++) q.push_back('{4'd5, 1'b0, junk(), z, 1'b0});
                  q.push_back('{4'd5, 1'b1, junk(), z, 1'b1}); end
      BEQ:  q.push_back('{4'd8, 1'($urandom), junk(), z, 1'b1});
      ADDI: begin q.push_back('{4'd9, 1'($urandom), junk(), z, 1'b0});
                  q.push_back('{4'd10, 1'($urandom), junk(), z, 1'b1}); end
      JMP:  q.push_back('{4'd11, 1'($urandom), junk(), z, 1'b1});
      default: ;
    endcase
  endtask

  // Apply queued steps, checking state, controls and retired each cycle
  task automatic run_q(output int n_memrd, output bit saw_max);
    cyc_t e;
    n_memrd = 0;
    saw_max = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.mr; Opcode = e.op; Zero = e.z; Funct = 6'($urandom);
      @(negedge clk);
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'(act_c), 32'(model_ctrl(e.st, e.mr, e.z, e.op)));
      chk("retired", 32'(retired), 32'(exp_ret));
      if (state == 4'd3) n_memrd++;
      if (retired == 4'hF) saw_max = 1'b1;
      if (e.ret_inc) exp_ret = (exp_ret + 1) % CMOD;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0; Opcode = '0; Zero = 1'b0; Funct = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(act_c), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    int  nrd;
    bit  smax;
    int  sel;
    logic [5:0] op;
    n_tests = 0; n_fail = 0; exp_ret = 0;
    rst = 1'b1; mem_ready = 1'b0; Opcode = '0; Zero = 1'b0; Funct = '0;

    //         mr    op       z     st     pcen  rw    ill   ret
    vecs[0]  = '{1'b1, RT,     1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, RT,     1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, LW,     1'b0, 4'd6,  1'b0, 1'b0, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, SW,     1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, RT,     1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd1};
    vecs[5]  = '{1'b1, RT,     1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd1};
    vecs[6]  = '{1'b1, BEQ,    1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 4'd1};
    vecs[7]  = '{1'b1, RT,     1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 4'd1};
    vecs[8]  = '{1'b1, RT,     1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd2};
    vecs[9]  = '{1'b1, BEQ,    1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 4'd2};
    vecs[10] = '{1'b1, RT,     1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 4'd2};
    vecs[11] = '{1'b1, RT,     1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd3};
    vecs[12] = '{1'b1, 6'h3F,  1'b0, 4'd1,  1'b0, 1'b0, 1'b1, 4'd3};
    vecs[13] = '{1'b1, RT,     1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd3};
    vecs[14] = '{1'b1, ADDI,   1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 4'd3};
    vecs[15] = '{1'b1, JMP,    1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 4'd3};
    vecs[16] = '{1'b1, BEQ,    1'b0, 4'd10, 1'b0, 1'b1, 1'b0, 4'd3};
    vecs[17] = '{1'b1, RT,     1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd4};
    vecs[18] = '{1'b1, JMP,    1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 4'd4};
    vecs[19] = '{1'b0, RT,     1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[20] = '{1'b0, RT,     1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd5};

    do_reset();

    // Directed vector table: R-type, BEQ taken/not taken, illegal, ADDI, J
    for (int i = 0; i < 21; i++) begin
      mem_ready = vecs[i].mr; Opcode = vecs[i].op; Zero = vecs[i].z; Funct = 6'($urandom);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d_pcen", i), 32'(PCEn), 32'(vecs[i].exp_pcen));
      chk($sformatf("vec%0d_regwrite", i), 32'(RegWrite), 32'(vecs[i].exp_rw));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].exp_ill));
      chk($sformatf("vec%0d_retired", i), 32'(retired), 32'(vecs[i].exp_ret));
      chk($sformatf("vec%0d_ctrl", i), 32'(act_c),
          32'(model_ctrl(vecs[i].exp_st, vecs[i].mr, vecs[i].z, vecs[i].op)));
      @(posedge clk); #1;
    end
    exp_ret = 5;

    // LW with three not-ready cycles in MEMRD
    push_instr(LW, 1, 3, 1'b0);
    run_q(nrd, smax);
    chk("lw_memrd_cycles", 32'(nrd), 32'd4);

    // Reset asserted while MEMWR waits on memory
    q.push_back('{4'd0, 1'b1, junk(), 1'b0, 1'b0});
    q.push_back('{4'd1, 1'b0, SW, 1'b0, 1'b0});
    q.push_back('{4'd2, 1'b1, junk(), 1'b0, 1'b0});
    q.push_back('{4'd5, 1'b0, junk(), 1'b0, 1'b0});
    run_q(nrd, smax);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_ctrl", 32'(act_c), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("midrst_memwrite", 32'(MemWrite), 32'd0);
    chk("midrst_ctrl_hold", 32'(act_c), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("post_rst_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;

    // Sixteen jumps wrap the 4-bit retired counter
    for (int i = 0; i < 16; i++) push_instr(JMP, 0, 0, 1'($urandom));
    run_q(nrd, smax);
    chk("wrap_saw_15", 32'(smax), 32'd1);
    chk("wrap_to_zero", 32'(retired), 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: op = RT;
        1: op = LW;
        2: op = SW;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        default: begin
          op = junk();
          while (is_legal(op)) op = junk();
        end
      endcase
      push_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom));
      run_q(nrd, smax);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
